// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests under a credit cap and buffers
// returned words with their PC in a small FIFO presented to decode with valid/ready.
package pipeline_pkg;
    localparam int XLEN = 64;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] PCPlus4;
    } ifid_t;
endpackage

module fetch_unit
    import pipeline_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            ifid_valid,
    input  logic            ifid_ready,
    output ifid_t           ifid_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0] pcQ;
    logic [XLEN-1:0] rspPcQ;
    logic [CW-1:0]   outst;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rdPtr;
    logic [PW-1:0]   wrPtr;
    ifid_t           fifoMem [DEPTH];

    logic            reqFire;
    logic            popFire;
    logic            keepRsp;
    logic [CW:0]     inUse;
    ifid_t           pushEntry;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits cover both in-flight requests and buffered words, so a response always finds room.
    assign inUse          = {1'b0, outst} + {1'b0, count};
    assign imem_req_valid = rst_n && !redirect_valid && (inUse < (CW+1)'(DEPTH));
    assign imem_req_addr  = pcQ;

    assign reqFire   = imem_req_valid && imem_req_ready;
    assign popFire   = ifid_valid && ifid_ready;
    assign keepRsp   = imem_rsp_valid && (drop == '0);
    assign pushEntry = '{instr: imem_rsp_data, PC: rspPcQ, PCPlus4: rspPcQ + XLEN'(4)};

    assign ifid_valid = (count != '0);
    assign ifid_o     = ifid_valid ? fifoMem[rdPtr] : '0;

    // NOTE: storage carries no reset; the count gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (rst_n && !redirect_valid && keepRsp) begin
            fifoMem[wrPtr] <= pushEntry;
        end
    end

    // NOTE: all state updates use <= so every branch reads pre-edge values of the counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcQ    <= RESET_PC;
            rspPcQ <= RESET_PC;
            outst  <= '0;
            drop   <= '0;
            count  <= '0;
            rdPtr  <= '0;
            wrPtr  <= '0;
        end else if (redirect_valid) begin
            // Everything still outstanding after this edge belongs to the old path.
            pcQ    <= redirect_pc;
            rspPcQ <= redirect_pc;
            outst  <= outst - CW'(imem_rsp_valid);
            drop   <= outst - CW'(imem_rsp_valid);
            count  <= '0;
            rdPtr  <= '0;
            wrPtr  <= '0;
        end else begin
            if (reqFire) begin
                pcQ <= pcQ + XLEN'(4);
            end
            outst <= outst + CW'(reqFire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
            if (keepRsp) begin
                wrPtr  <= nextPtr(wrPtr);
                rspPcQ <= rspPcQ + XLEN'(4);
            end
            if (popFire) begin
                rdPtr <= nextPtr(rdPtr);
            end
            count <= count + CW'(keepRsp) - CW'(popFire);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a fixed-latency instruction memory model, a monitor of
// words handed to decode, and a linear sequence of scenarios with hand-computed values.
module tb_fetch_unit;
    import pipeline_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [31:0]     imem_rsp_data  = '0;
    logic            ifid_valid;
    logic            ifid_ready;
    ifid_t           ifidO;

    int nChecks = 0;
    int nFail   = 0;
    int memLat  = 1;
    int edgeCnt = 0;

    logic [XLEN-1:0] pendAddr [$];
    int              pendDue  [$];
    logic [XLEN-1:0] gotPc    [$];
    logic [31:0]     gotInstr [$];

    fetch_unit #(.DEPTH(2), .RESET_PC('0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ifid_valid     (ifid_valid),
        .ifid_ready     (ifid_ready),
        .ifid_o         (ifidO)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instrOf(input logic [XLEN-1:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory: a request accepted at edge k answers at edge k+memLat, in order.
    always @(posedge clk) begin : memModel
        logic            fire;
        logic [XLEN-1:0] addr;
        fire = imem_req_valid && imem_req_ready;
        addr = imem_req_addr;
        if (!rst_n) begin
            pendAddr.delete();
            pendDue.delete();
        end else begin
            if (imem_rsp_valid && pendAddr.size() > 0) begin
                void'(pendAddr.pop_front());
                void'(pendDue.pop_front());
            end
            if (fire) begin
                pendAddr.push_back(addr);
                pendDue.push_back(edgeCnt + memLat);
            end
        end
        edgeCnt = edgeCnt + 1;
        #1;
        if (pendAddr.size() > 0 && pendDue[0] == edgeCnt) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instrOf(pendAddr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && !redirect_valid && ifid_valid && ifid_ready) begin
            gotPc.push_back(ifidO.PC);
            gotInstr.push_back(ifidO.instr);
        end
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkPc(input int idx, input logic [XLEN-1:0] exp, input string tag);
        logic present;
        present = (gotPc.size() > idx);
        check({tag, "_present"}, present, 1'b1);
        if (present) begin
            check({tag, "_pc"}, gotPc[idx], exp);
            check({tag, "_instr"}, gotInstr[idx], instrOf(exp));
        end
    endtask

    task automatic doReset(input int lat, input logic reqRdy, input logic idRdy);
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(negedge clk);
        memLat         = lat;
        imem_req_ready = reqRdy;
        ifid_ready     = idRdy;
        gotPc.delete();
        gotInstr.delete();
        rst_n          = 1'b1;
        #1;
    endtask

    initial begin
        int n200;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        ifid_ready     = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_ifid_valid", ifid_valid, 1'b0);
        check("rst_ifid_o", ifidO, '0);

        // Streaming with 1-cycle memory
        rst_n = 1'b1;
        #1;
        check("b_req_valid0", imem_req_valid, 1'b1);
        check("b_req_addr0", imem_req_addr, 64'h0);
        @(negedge clk); #1;
        check("b_req_addr1", imem_req_addr, 64'h4);
        check("b_ifid_valid1", ifid_valid, 1'b0);
        @(negedge clk); #1;
        check("b_ifid_valid2", ifid_valid, 1'b1);
        check("b_pc2", ifidO.PC, 64'h0);
        check("b_pcplus4_2", ifidO.PCPlus4, 64'h4);
        check("b_instr2", ifidO.instr, instrOf(64'h0));
        check("b_credit_cap", imem_req_valid, 1'b0);
        repeat (15) @(negedge clk);
        for (int i = 0; i < 6; i++) checkPc(i, 64'(i * 4), "b_flow");

        // Decode stall from the start
        doReset(1, 1'b1, 1'b0);
        @(negedge clk); #1;
        check("c_req_addr1", imem_req_addr, 64'h4);
        check("c_req_valid1", imem_req_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("c_hold_valid", ifid_valid, 1'b1);
            check("c_hold_pc", ifidO.PC, 64'h0);
            check("c_hold_req", imem_req_valid, 1'b0);
        end
        gotPc.delete();
        gotInstr.delete();
        ifid_ready = 1'b1;
        repeat (8) @(negedge clk);
        checkPc(0, 64'h0, "c_rel0");
        checkPc(1, 64'h4, "c_rel1");
        checkPc(2, 64'h8, "c_rel2");

        // 3-cycle memory, redirect with two requests in flight
        doReset(3, 1'b1, 1'b1);
        @(negedge clk); #1;
        check("d_req_addr1", imem_req_addr, 64'h4);
        @(negedge clk); #1;
        check("d_cap", imem_req_valid, 1'b0);
        gotPc.delete();
        gotInstr.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        #1;
        check("d_redir_req", imem_req_valid, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk); #1;
        check("d_req_valid", imem_req_valid, 1'b1);
        check("d_req_addr", imem_req_addr, 64'h100);
        check("d_ifid_empty", ifid_valid, 1'b0);
        repeat (10) @(negedge clk);
        checkPc(0, 64'h100, "d_new0");
        checkPc(1, 64'h104, "d_new1");

        // Redirect coincident with a response and a pop
        doReset(1, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk); #1;
        check("e_pre_valid", ifid_valid, 1'b1);
        gotPc.delete();
        gotInstr.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h400;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("e_ifid_empty", ifid_valid, 1'b0);
        check("e_ifid_o_zero", ifidO, '0);
        check("e_req_valid", imem_req_valid, 1'b1);
        check("e_req_addr", imem_req_addr, 64'h400);
        repeat (8) @(negedge clk);
        checkPc(0, 64'h400, "e_new0");
        checkPc(1, 64'h404, "e_new1");

        // Back-to-back redirects: last one wins
        doReset(3, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        gotPc.delete();
        gotInstr.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        @(negedge clk);
        redirect_pc = 64'h300;
        #1;
        check("f_redir_req", imem_req_valid, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("f_req_valid", imem_req_valid, 1'b1);
        check("f_req_addr", imem_req_addr, 64'h300);
        check("f_ifid_empty", ifid_valid, 1'b0);
        repeat (12) @(negedge clk);
        checkPc(0, 64'h300, "f_new0");
        n200 = 0;
        foreach (gotPc[i]) if (gotPc[i] == 64'h200) n200++;
        check("f_no_0x200", n200, 0);

        // Memory stall, then reset mid-stall
        doReset(1, 1'b1, 1'b1);
        @(negedge clk);
        imem_req_ready = 1'b0;
        #1;
        check("g_req_addr", imem_req_addr, 64'h4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("g_stall_valid", imem_req_valid, 1'b1);
            check("g_stall_addr", imem_req_addr, 64'h4);
        end
        rst_n = 1'b0;
        #1;
        check("g_rst_req_now", imem_req_valid, 1'b0);
        @(negedge clk); #1;
        check("g_rst_req", imem_req_valid, 1'b0);
        check("g_rst_ifid_valid", ifid_valid, 1'b0);
        check("g_rst_ifid_o", ifidO, '0);
        imem_req_ready = 1'b1;
        gotPc.delete();
        gotInstr.delete();
        rst_n = 1'b1;
        #1;
        check("g_restart_valid", imem_req_valid, 1'b1);
        check("g_restart_addr", imem_req_addr, 64'h0);
        repeat (6) @(negedge clk);
        checkPc(0, 64'h0, "g_new0");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
